// File: rtl/sort_elem_serializer_pkg.sv
// Shared types and helpers for the sorted-bundle serializer: FSM states,
// default element width and a packed-bundle element extractor.
package sort_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_NBITS   = 8;
    localparam int unsigned MAX_NBITS       = 64;
    localparam int unsigned MAX_BUNDLE_BITS = 1024;

    // Callers zero-extend their bundle to MAX_BUNDLE_BITS and cast the
    // result back down to their own element width.
    function automatic logic [MAX_NBITS-1:0] elem_at(
        input logic [MAX_BUNDLE_BITS-1:0] bundle,
        input int unsigned                nbits,
        input int unsigned                i
    );
        logic [MAX_BUNDLE_BITS-1:0] shifted;
        logic [MAX_NBITS-1:0]       mask;
        shifted = bundle >> (i * nbits);
        mask    = {MAX_NBITS{1'b1}} >> (MAX_NBITS - nbits);
        return MAX_NBITS'(shifted) & mask;
    endfunction

endpackage

// File: rtl/sort_elem_serializer_if.sv
// Bundle-in / element-out handshake bundle for the serializer.
// master = producer/consumer side (bench), slave = serializer side.
interface sort_elem_serializer_if
    import sort_pkg::*;
#(
    parameter int p_nbits  = DEFAULT_NBITS,
    parameter int p_nelems = 4
);
    logic                         in_val;
    logic                         in_rdy;
    logic [p_nelems*p_nbits-1:0]  in_msg;
    logic                         out_val;
    logic                         out_rdy;
    logic [p_nbits-1:0]           out_msg;
    logic                         out_last;
    logic                         err_unsorted;

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_last, err_unsorted
    );

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_last, err_unsorted
    );
endinterface

// File: rtl/sort_elem_serializer_checker.sv
// Combinational adjacent-pair check: ok=1 when the bundle is non-decreasing
// (unsigned, equal neighbours allowed).
module sort_order_checker
    import sort_pkg::*;
#(
    parameter int p_nbits  = DEFAULT_NBITS,
    parameter int p_nelems = 4
) (
    input  logic [p_nelems*p_nbits-1:0] bundle,
    output logic                        ok
);
    logic [p_nbits-1:0] lo_elem;
    logic [p_nbits-1:0] hi_elem;

    always_comb begin
        ok      = 1'b1;
        lo_elem = '0;
        hi_elem = '0;
        for (int i = 0; i < p_nelems - 1; i++) begin
            lo_elem = p_nbits'(elem_at(MAX_BUNDLE_BITS'(bundle), p_nbits, i));
            hi_elem = p_nbits'(elem_at(MAX_BUNDLE_BITS'(bundle), p_nbits, i + 1));
            if (hi_elem < lo_elem) begin
                ok = 1'b0;
            end
        end
    end
endmodule

// File: rtl/sort_elem_serializer.sv
// Serializes one sorted bundle into p_nelems element transfers, minimum first,
// with a sticky flag for any accepted bundle that is not non-decreasing.
module sort_elem_serializer
    import sort_pkg::*;
#(
    parameter int p_nbits  = DEFAULT_NBITS,
    parameter int p_nelems = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    sort_elem_serializer_if.slave  io
);
    localparam int IDX_W = $clog2(p_nelems);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p_nelems - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [p_nelems*p_nbits-1:0]  buf_q, buf_d;
    logic                         err_q, err_d;

    logic sorted_ok;
    logic at_last;
    logic in_rdy_c;
    logic accept;

    sort_order_checker #(
        .p_nbits  (p_nbits),
        .p_nelems (p_nelems)
    ) u_checker (
        .bundle (io.in_msg),
        .ok     (sorted_ok)
    );

    assign at_last = (idx_q == LAST_IDX);

    // The out_rdy term lets the next bundle load on the same edge the last
    // element leaves; reset gating keeps in_rdy low while reset is held.
    assign in_rdy_c = !reset &&
                      ((state_q == IDLE) || (state_q == SEND && at_last && io.out_rdy));
    assign accept   = io.in_val && in_rdy_c;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (io.out_rdy) begin
                    if (!at_last) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!accept) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            buf_d = io.in_msg;
            idx_d = '0;
            if (!sorted_ok) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    assign io.in_rdy       = in_rdy_c;
    assign io.out_val      = (state_q == SEND);
    assign io.out_last     = (state_q == SEND) && at_last;
    assign io.out_msg      = p_nbits'(elem_at(MAX_BUNDLE_BITS'(buf_q), p_nbits, 32'(idx_q)));
    assign io.err_unsorted = err_q;
endmodule

// File: tb/tb_sort_elem_serializer.sv
// Directed scenarios plus a randomized run against a queue-based model of
// the serializer (expected elements = concatenation of accepted bundles).
module tb_sort_elem_serializer;
    import sort_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sort_elem_serializer_if #(.p_nbits(8), .p_nelems(4)) ia ();
    sort_elem_serializer_if #(.p_nbits(8), .p_nelems(2)) ib ();

    sort_elem_serializer #(.p_nbits(8), .p_nelems(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .io    (ia)
    );

    sort_elem_serializer #(.p_nbits(8), .p_nelems(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .io    (ib)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] pack4(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ia.in_val = 1'b0; ia.in_msg = '0; ia.out_rdy = 1'b1;
        ib.in_val = 1'b0; ib.in_msg = '0; ib.out_rdy = 1'b1;
        #3;
        n_checks++;
        if ({ia.out_val, ia.out_last, ia.in_rdy, ia.err_unsorted, ia.out_msg} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outs_a: got %h want 000",
                     {ia.out_val, ia.out_last, ia.in_rdy, ia.err_unsorted, ia.out_msg});
        end
        n_checks++;
        if ({ib.out_val, ib.out_last, ib.in_rdy, ib.err_unsorted, ib.out_msg} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outs_b: got %h want 000",
                     {ib.out_val, ib.out_last, ib.in_rdy, ib.err_unsorted, ib.out_msg});
        end
        tick(); tick();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ia.in_rdy, ia.out_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got rdy/val %b want 10", {ia.in_rdy, ia.out_val});
        end
    endtask

    task automatic test_basic();
        logic [7:0] e [4];
        e = '{8'h03, 8'h17, 8'h17, 8'hC2};
        tick();
        ia.in_msg = pack4(e[0], e[1], e[2], e[3]);
        ia.in_val = 1'b1; ia.out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ia.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL basic_accept_rdy: got %b want 1", ia.in_rdy);
        end
        tick();
        ia.in_val = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ia.out_val, ia.out_last, ia.in_rdy, ia.err_unsorted, ia.out_msg} !==
                {1'b1, (k == 3), (k == 3), 1'b0, e[k]}) begin
                n_fail++;
                $display("FAIL basic_elem%0d: got val/last/rdy/err/msg %b%b%b%b %h want 1%b%b0 %h",
                         k, ia.out_val, ia.out_last, ia.in_rdy, ia.err_unsorted, ia.out_msg,
                         (k == 3), (k == 3), e[k]);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({ia.out_val, ia.in_rdy} !== 2'b01) begin
            n_fail++; $display("FAIL basic_idle: got val/rdy %b want 01", {ia.out_val, ia.in_rdy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [8];
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
        tick();
        ia.in_msg = pack4(e[0], e[1], e[2], e[3]);
        ia.in_val = 1'b1; ia.out_rdy = 1'b1;
        tick();
        ia.in_msg = pack4(e[4], e[5], e[6], e[7]);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ia.out_val, ia.in_rdy, ia.out_msg} !== {1'b1, (c == 3 || c == 7), e[c]}) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got val/rdy/msg %b%b %h want 1%b %h",
                         c, ia.out_val, ia.in_rdy, ia.out_msg, (c == 3 || c == 7), e[c]);
            end
            tick();
            if (c == 3) ia.in_val = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (ia.out_val !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got out_val %b want 0", ia.out_val);
        end
    endtask

    task automatic test_backpressure();
        tick();
        ia.in_msg = pack4(8'h01, 8'h02, 8'h03, 8'h04);
        ia.in_val = 1'b1; ia.out_rdy = 1'b1;
        tick();
        ia.in_val = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ia.out_val, ia.out_msg} !== {1'b1, 8'h01}) begin
            n_fail++; $display("FAIL bp_first: got %b %h want 1 01", ia.out_val, ia.out_msg);
        end
        tick();
        ia.out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ia.out_val, ia.out_last, ia.out_msg} !== {2'b10, 8'h02}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got val/last/msg %b%b %h want 10 02",
                         i, ia.out_val, ia.out_last, ia.out_msg);
            end
            tick();
        end
        ia.out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ia.out_msg !== 8'h02) begin
            n_fail++; $display("FAIL bp_release: got %h want 02", ia.out_msg);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({ia.out_val, ia.out_msg} !== {1'b1, 8'h03}) begin
            n_fail++; $display("FAIL bp_next: got %b %h want 1 03", ia.out_val, ia.out_msg);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({ia.out_val, ia.out_last, ia.out_msg} !== {2'b11, 8'h04}) begin
            n_fail++; $display("FAIL bp_last: got %b%b %h want 11 04", ia.out_val, ia.out_last, ia.out_msg);
        end
        tick();
    endtask

    task automatic test_unsorted();
        logic [7:0] e [4];
        e = '{8'h05, 8'h04, 8'h06, 8'h07};
        ia.in_msg = pack4(e[0], e[1], e[2], e[3]);
        ia.in_val = 1'b1; ia.out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ia.err_unsorted !== 1'b0) begin
            n_fail++; $display("FAIL unsorted_pre: got err %b want 0", ia.err_unsorted);
        end
        tick();
        ia.in_val = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ia.out_val, ia.err_unsorted, ia.out_msg} !== {2'b11, e[k]}) begin
                n_fail++;
                $display("FAIL unsorted_elem%0d: got val/err/msg %b%b %h want 11 %h",
                         k, ia.out_val, ia.err_unsorted, ia.out_msg, e[k]);
            end
            tick();
        end
        ia.in_msg = pack4(8'h01, 8'h02, 8'h03, 8'h04);
        ia.in_val = 1'b1;
        tick();
        ia.in_val = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ia.err_unsorted, ia.out_msg} !== {1'b1, 8'(k + 1)}) begin
                n_fail++;
                $display("FAIL unsorted_sticky%0d: got err/msg %b %h want 1 %h",
                         k, ia.err_unsorted, ia.out_msg, 8'(k + 1));
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        ia.in_msg = pack4(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        ia.in_val = 1'b1; ia.out_rdy = 1'b1;
        tick();
        ia.in_val = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++;
        if ({ia.out_val, ia.out_msg} !== {1'b1, 8'h0B}) begin
            n_fail++; $display("FAIL midrst_second: got %b %h want 1 0b", ia.out_val, ia.out_msg);
        end
        tick();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({ia.out_val, ia.err_unsorted, ia.in_rdy, ia.out_last, ia.out_msg} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_async: got %h want 000",
                     {ia.out_val, ia.err_unsorted, ia.in_rdy, ia.out_last, ia.out_msg});
        end
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ia.out_val, ia.in_rdy} !== 2'b01) begin
                n_fail++; $display("FAIL midrst_after%0d: got val/rdy %b want 01", i, {ia.out_val, ia.in_rdy});
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] e [4];
        e = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        tick();
        ia.in_msg = pack4(e[0], e[1], e[2], e[3]);
        ia.in_val = 1'b1; ia.out_rdy = 1'b1;
        tick();
        ia.in_val = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ia.out_val, ia.out_last, ia.err_unsorted, ia.out_msg} !== {1'b1, (k == 3), 1'b0, e[k]}) begin
                n_fail++;
                $display("FAIL bound_eq%0d: got val/last/err/msg %b%b%b %h want 1%b0 %h",
                         k, ia.out_val, ia.out_last, ia.err_unsorted, ia.out_msg, (k == 3), e[k]);
            end
            tick();
        end
        ib.in_msg = {8'h00, 8'hFF};
        ib.in_val = 1'b1; ib.out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ib.in_rdy, ib.err_unsorted} !== 2'b10) begin
            n_fail++; $display("FAIL bound_n2_pre: got rdy/err %b want 10", {ib.in_rdy, ib.err_unsorted});
        end
        tick();
        ib.in_val = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ib.out_val, ib.out_last, ib.err_unsorted, ib.out_msg} !== {3'b101, 8'hFF}) begin
            n_fail++;
            $display("FAIL bound_n2_e0: got %b%b%b %h want 101 ff", ib.out_val, ib.out_last, ib.err_unsorted, ib.out_msg);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({ib.out_val, ib.out_last, ib.err_unsorted, ib.out_msg} !== {3'b111, 8'h00}) begin
            n_fail++;
            $display("FAIL bound_n2_e1: got %b%b%b %h want 111 00", ib.out_val, ib.out_last, ib.err_unsorted, ib.out_msg);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({ib.out_val, ib.err_unsorted} !== 2'b01) begin
            n_fail++; $display("FAIL bound_n2_idle: got val/err %b want 01", {ib.out_val, ib.err_unsorted});
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_q [$];
        logic [7:0] v [$];
        logic [7:0] cur [4];
        logic       err_m;
        logic       exp_val, exp_rdy;
        @(negedge clk);
        reset = 1'b1;
        #2 reset = 1'b0;
        err_m = 1'b0;
        ia.in_val = 1'b0;
        for (int n = 0; n < 400; n++) begin
            tick();
            v.delete();
            for (int i = 0; i < 4; i++) begin
                if (n % 3 == 0) v.push_back(8'($urandom_range(0, 3)));
                else            v.push_back(8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 3) != 0) v.sort();
            for (int i = 0; i < 4; i++) cur[i] = v[i];
            ia.in_msg  = pack4(cur[0], cur[1], cur[2], cur[3]);
            ia.in_val  = ($urandom_range(0, 2) != 0);
            ia.out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_val = (exp_q.size() != 0);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ia.out_rdy);
            n_checks++;
            if ({ia.out_val, ia.in_rdy, ia.err_unsorted} !== {exp_val, exp_rdy, err_m}) begin
                n_fail++;
                $display("FAIL rand%0d_ctl: got val/rdy/err %b%b%b want %b%b%b",
                         n, ia.out_val, ia.in_rdy, ia.err_unsorted, exp_val, exp_rdy, err_m);
            end
            if (exp_val) begin
                n_checks++;
                if ({ia.out_last, ia.out_msg} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand%0d_data: got last/msg %b %h want %b %h",
                             n, ia.out_last, ia.out_msg, exp_q[0][8], exp_q[0][7:0]);
                end
                if (ia.out_rdy) void'(exp_q.pop_front());
            end
            if (ia.in_val && exp_rdy) begin
                for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), cur[i]});
                for (int i = 0; i < 3; i++) if (cur[i+1] < cur[i]) err_m = 1'b1;
            end
        end
        ia.in_val = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_unsorted();
        test_mid_reset();
        test_boundaries();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sort_elem_serializer.md
Name: sort_elem_serializer

Overview:
- Consumer end of the sort network's bundle output. Accepts one p_nelems-wide sorted bundle per transaction on a val/rdy port.
- Emits the elements one per transfer, index 0 (minimum) first, on a val/rdy stream with a last marker.
- Checks that each captured bundle is non-decreasing (unsigned) and raises a sticky error flag otherwise.
- Sits between the sorter pipeline and narrow downstream consumers such as the test sink and memory writer.

Parameters:
- p_nbits, 8, element width in bits
- p_nelems, 4, elements per bundle (legal range >= 2)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_val  input  1  bundle valid
- in_rdy  output  1  bundle ready
- in_msg  input  p_nelems*p_nbits  packed bundle; element i = in_msg[i*p_nbits +: p_nbits]
- out_val  output  1  element valid
- out_rdy  input  1  element ready
- out_msg  output  p_nbits  current element
- out_last  output  1  high while out_msg is element p_nelems-1
- err_unsorted  output  1  sticky: some accepted bundle had element i+1 < element i

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset state: state=IDLE, idx=0, err_unsorted=0, buffer cleared to 0.
  - Outputs during reset: out_val=0, out_last=0, out_msg=0, in_rdy=0.
- Reset mid-operation: any buffered bundle is discarded without emission. After reset deasserts the block is in IDLE.
- Transfers occur on a rising edge with val && rdy. All state is registered. out_* are driven from registers/state only, with no combinational path from in_* to out_*.
- FSM states:
  - IDLE:
    - out_val=0; in_rdy=1.
    - On in_val: capture in_msg into buffer, idx<=0, go to SEND.
  - SEND:
    - out_val=1, out_msg=buffer[idx], out_last=(idx==p_nelems-1).
    - On out_rdy with idx<p_nelems-1: idx<=idx+1.
    - On out_rdy with idx==p_nelems-1: if in_val, capture the new bundle, idx<=0 and stay in SEND; else go to IDLE.
- in_rdy = IDLE || (SEND && idx==p_nelems-1 && out_rdy). This combinational out_rdy->in_rdy path is intentional and gives zero-bubble back-to-back bundles.
- Latency: first element is valid the cycle after bundle acceptance.
- Throughput: p_nelems cycles per bundle with out_rdy held high.
- Backpressure: with out_rdy=0, out_msg, out_last and idx hold stable, and out_val stays 1 (no retraction).
- idx width is $clog2(p_nelems). idx never exceeds p_nelems-1; there is no wrap past the last element.
- Sort check:
  - Evaluated on in_msg at capture time only, over all adjacent pairs, unsigned; equal values are legal.
  - If any pair violates, err_unsorted<=1 on that edge. It stays 1 until reset.
  - The bundle is still serialized unchanged.

Decomposition:
- Shared package sort_pkg holds:
  - the state enum (IDLE, SEND);
  - localparam for the default element width;
  - a function extracting element i from a packed bundle.
- One sub-module is natural: sort_order_checker, a combinational p_nelems-wide adjacent-pair <= check that outputs a single ok bit. Instantiated once on in_msg.

Test Plan:
1. Basic: reset, then bundle {idx0..3}=03,17,17,C2 with out_rdy=1 -> accepted cycle 0; out_msg 03,17,17,C2 on cycles 1-4; out_last only on C2; err_unsorted=0; in_rdy=0 during cycles 1-3.
2. Back-to-back: two bundles 01,02,03,04 and 10,20,30,40, in_val held, out_rdy=1 -> eight consecutive valid outputs with no idle cycle; second bundle accepted on the cycle 04 transfers.
3. Backpressure: out_rdy=0 for 3 cycles while out_msg=02 -> out_msg=02, out_val=1 stable; then 03 appears the cycle after out_rdy rises.
4. Unsorted: bundle 05,04,06,07 -> err_unsorted=1 from the cycle after acceptance; outputs 05,04,06,07 unchanged; flag persists through a later sorted bundle.
5. Mid-operation reset: assert reset asynchronously after the second element -> out_val and err_unsorted drop immediately; after release, in_rdy=1 and no residual elements are emitted.
6. Boundaries: p_nbits=8 with bundle 00,00,FF,FF -> err_unsorted=0; with p_nelems=2 and bundle FF,00 -> outputs FF then 00 (out_last=1), err_unsorted=1.
